// File: rtl/fetch2_redirect_pipe.sv
// Second fetch stage: finds the first effective CTI, builds lane masks, allocates CTI-queue tags, redirects on BTB miss.
// Latency 1 (registered output); accepts only when the output slot frees, the CTI queue has room and no flush is present.
// Optional macro FS2_RAS_OVERRIDE_EN: a return-lane redirect uses ras_top_i instead of lane_target_i.
module fetch2_redirect_pipe #(
    parameter int FETCH_WIDTH = 4,
    parameter int PC_W        = 32,
    parameter int INST_STRIDE = 8,
    parameter int CTIQ_DEPTH  = 16,
    parameter int TAG_W       = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [PC_W-1:0]             pc_i,
    input  logic [FETCH_WIDTH-1:0]      lane_ctrl_i,
    input  logic [2*FETCH_WIDTH-1:0]    lane_type_i,
    input  logic [FETCH_WIDTH-1:0]      lane_pred_i,
    input  logic [FETCH_WIDTH-1:0]      lane_btbhit_i,
    input  logic [FETCH_WIDTH*PC_W-1:0] lane_target_i,
    input  logic [PC_W-1:0]             ras_top_i,
    input  logic [TAG_W:0]              commit_cnt_i,
    input  logic                        flush_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [FETCH_WIDTH-1:0]      out_mask_o,
    output logic [FETCH_WIDTH-1:0]      out_ctrl_mask_o,
    output logic [TAG_W-1:0]            out_tag_base_o,
    output logic                        redirect_o,
    output logic [PC_W-1:0]             redirect_pc_o,
    output logic                        redirect_rtr_o,
    output logic                        redirect_call_o,
    output logic [PC_W-1:0]             call_pc_o,
    output logic                        ctiq_full_o
);

    localparam int SEL_W = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
    localparam logic [PC_W-1:0]  STRIDE   = PC_W'(INST_STRIDE);
    localparam logic [TAG_W:0]   FULL_THR = (TAG_W+1)'(CTIQ_DEPTH - FETCH_WIDTH);

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            rtr;
        logic            call;
        logic [PC_W-1:0] call_pc;
    } redir_t;

    logic [FETCH_WIDTH-1:0] eff;
    logic [FETCH_WIDTH-1:0] keep;
    logic [FETCH_WIDTH-1:0] ctrl_mask;
    logic [SEL_W-1:0]       sel;
    logic                   has_eff;
    logic [1:0]             sel_type;
    logic [PC_W-1:0]        sel_target;
    logic                   sel_btbhit;
    logic [TAG_W:0]         alloc;
    logic                   accept;
    logic                   take_redirect;
    redir_t                 redir_next;

    logic [TAG_W-1:0]       tail;
    logic [TAG_W-1:0]       head;
    logic [TAG_W:0]         occ;
    logic [TAG_W+1:0]       occ_sum;
    logic [TAG_W:0]         occ_next;

    // Not-taken conditionals are CTIs but do not end the bundle.
    always_comb begin
        eff = '0;
        for (int i = 0; i < FETCH_WIDTH; i++)
            eff[i] = lane_ctrl_i[i] & (lane_pred_i[i] | (lane_type_i[2*i +: 2] != 2'b11));
    end

    always_comb begin
        has_eff    = 1'b0;
        sel        = '0;
        sel_type   = 2'b00;
        sel_target = '0;
        sel_btbhit = 1'b0;
        for (int i = FETCH_WIDTH-1; i >= 0; i--) begin
            if (eff[i]) begin
                has_eff    = 1'b1;
                sel        = SEL_W'(i);
                sel_type   = lane_type_i[2*i +: 2];
                sel_target = lane_target_i[i*PC_W +: PC_W];
                sel_btbhit = lane_btbhit_i[i];
            end
        end
    end

    always_comb begin
        keep  = '0;
        alloc = '0;
        for (int i = 0; i < FETCH_WIDTH; i++)
            keep[i] = !has_eff || (SEL_W'(i) <= sel);
        ctrl_mask = lane_ctrl_i & keep;
        for (int i = 0; i < FETCH_WIDTH; i++)
            alloc = alloc + (TAG_W+1)'(ctrl_mask[i]);
    end

    assign ctiq_full_o   = occ > FULL_THR;
    assign in_ready_o    = reset & (!out_valid_o | out_ready_i) & !ctiq_full_o & !flush_i;
    assign accept        = in_valid_i & in_ready_o;
    assign take_redirect = accept & has_eff & !sel_btbhit;

    always_comb begin
        redir_next.rtr     = (sel_type == 2'b00);
        redir_next.call    = (sel_type == 2'b01);
        redir_next.call_pc = redir_next.call ? pc_i + STRIDE * PC_W'(sel) : '0;
`ifdef FS2_RAS_OVERRIDE_EN
        redir_next.pc      = redir_next.rtr ? ras_top_i : sel_target;
`else
        redir_next.pc      = sel_target;
`endif
    end

    // Commits beyond what is outstanding clamp occupancy at zero.
    always_comb begin
        occ_sum  = {1'b0, occ} + (accept ? {1'b0, alloc} : '0);
        occ_next = (occ_sum > {1'b0, commit_cnt_i}) ? (TAG_W+1)'(occ_sum - {1'b0, commit_cnt_i}) : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tail <= '0;
            head <= '0;
            occ  <= '0;
        end else begin
            head <= head + commit_cnt_i[TAG_W-1:0];
            if (flush_i) begin
                tail <= head + commit_cnt_i[TAG_W-1:0];
                occ  <= '0;
            end else begin
                if (accept)
                    tail <= tail + alloc[TAG_W-1:0];
                occ <= occ_next;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_o     <= 1'b0;
            out_mask_o      <= '0;
            out_ctrl_mask_o <= '0;
            out_tag_base_o  <= '0;
            redirect_o      <= 1'b0;
            redirect_pc_o   <= '0;
            redirect_rtr_o  <= 1'b0;
            redirect_call_o <= 1'b0;
            call_pc_o       <= '0;
        end else begin
            redirect_o      <= take_redirect;
            redirect_pc_o   <= take_redirect ? redir_next.pc : '0;
            redirect_rtr_o  <= take_redirect & redir_next.rtr;
            redirect_call_o <= take_redirect & redir_next.call;
            call_pc_o       <= take_redirect ? redir_next.call_pc : '0;
            if (flush_i) begin
                out_valid_o <= 1'b0;
            end else if (accept) begin
                out_valid_o     <= 1'b1;
                out_mask_o      <= keep;
                out_ctrl_mask_o <= ctrl_mask;
                out_tag_base_o  <= tail;
            end else if (out_ready_i) begin
                out_valid_o <= 1'b0;
            end
        end
    end

endmodule
